// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the five-stage pipeline.
// Merges the memory wait, the multiply/divide occupancy of EX, the load-use
// pause from ID and the taken-branch redirect into hold (stall_o) and
// bubble (flush_o) controls for PC, IF/ID, ID/EX, EX/ME and ME/WB.
// Also owns the MDU cycle counter and a sticky memory-wait watchdog.
// Optional build macro: DELAY_SLOT_EN. When it is defined, the branch delay
// slot executes and a taken branch squashes nothing.
module pipe_hazard_ctrl #(
   parameter int unsigned MUL_CYCLES  = 4,
   parameter int unsigned DIV_CYCLES  = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_pause_i,
   input  logic       br_taken_i,
   input  logic       mdu_start_i,
   input  logic       mdu_div_i,
   input  logic       mem_req_i,
   input  logic       mem_ack_i,
   output logic [4:0] stall_o,
   output logic [4:0] flush_o,
   output logic       mdu_busy_o,
   output logic       mdu_done_o,
   output logic       mem_timeout_o
);

   // Counter reload values: the start cycle is the first of the N EX cycles.
   localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES - 1);
   localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES - 1);

   // Watchdog counter spans 0..MEM_TIMEOUT.
   localparam int unsigned WW    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] WMAX  = WW'(MEM_TIMEOUT);
   localparam logic [WW-1:0] WTRIP = WW'(MEM_TIMEOUT - 1);

   // Stall/flush patterns, bit0 PC .. bit4 ME/WB.
   localparam logic [4:0] MEM_STALL = 5'b01111;
   localparam logic [4:0] MEM_FLUSH = 5'b10000;
   localparam logic [4:0] MDU_STALL = 5'b00111;
   localparam logic [4:0] MDU_FLUSH = 5'b01000;
   localparam logic [4:0] LU_STALL  = 5'b00011;
   localparam logic [4:0] LU_FLUSH  = 5'b00100;
`ifdef DELAY_SLOT_EN
   localparam logic [4:0] BR_FLUSH  = 5'b00000;
`else
   localparam logic [4:0] BR_FLUSH  = 5'b00010;
`endif

   typedef enum logic {IDLE, BUSY} mdu_state_t;

   mdu_state_t    state, state_nxt;
   logic [5:0]    cnt, cnt_nxt;
   logic          mdu_hold, mdu_done;
   logic          memwait;
   logic [WW-1:0] wcnt;
   logic          timeout_q;

   // ME cannot advance while its access is outstanding.
   assign memwait = mem_req_i & ~mem_ack_i;

   // MDU state and cycle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // MDU next state, EX hold request and completion pulse.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mdu_hold  = 1'b0;
      mdu_done  = 1'b0;
      case (state)
         IDLE: begin
            if (mdu_start_i) begin
               mdu_hold = 1'b1;
               // Under memwait EX is frozen, so the start re-presents next cycle.
               if (!memwait) begin
                  cnt_nxt   = mdu_div_i ? DIV_LD : MUL_LD;
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt != 6'd0) begin
               // The unit keeps computing through a memory wait.
               mdu_hold = 1'b1;
               cnt_nxt  = cnt - 6'd1;
            end else if (!memwait) begin
               mdu_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Memory-wait watchdog: saturating run-length counter plus sticky flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt      <= '0;
         timeout_q <= 1'b0;
      end else if (memwait) begin
         if (wcnt != WMAX) wcnt <= wcnt + 1'b1;
         if (wcnt >= WTRIP) timeout_q <= 1'b1;
      end else begin
         wcnt <= '0;
      end
   end

   // Priority merge of hazard sources; a branch is only seen when IF/ID moves.
   always_comb begin
      stall_o    = '0;
      flush_o    = '0;
      mdu_done_o = 1'b0;
      if (!rst) begin
         mdu_done_o = mdu_done;
         if (memwait) begin
            stall_o = MEM_STALL;
            flush_o = MEM_FLUSH;
         end else if (mdu_hold) begin
            stall_o = MDU_STALL;
            flush_o = MDU_FLUSH;
         end else if (id_pause_i) begin
            stall_o = LU_STALL;
            flush_o = LU_FLUSH;
         end else if (br_taken_i) begin
            flush_o = BR_FLUSH;
         end
      end
   end

   assign mdu_busy_o    = (state == BUSY);
   assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle vector table followed by
// hand-written divide, watchdog and reset-mid-divide sequences.
module tb_pipe_hazard_ctrl;

   localparam int unsigned MUL_N = 4;
   localparam int unsigned DIV_N = 32;
   localparam int unsigned WD_N  = 4;

`ifdef DELAY_SLOT_EN
   localparam logic [4:0] BRF = 5'b00000;
`else
   localparam logic [4:0] BRF = 5'b00010;
`endif

   logic       clk, rst;
   logic       id_pause_i, br_taken_i, mdu_start_i, mdu_div_i, mem_req_i, mem_ack_i;
   logic [4:0] stall_o, flush_o;
   logic       mdu_busy_o, mdu_done_o, mem_timeout_o;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       rst, pause, br, start, div, req, ack;
      logic [4:0] stall, flush;
      logic       done, busy, to;
   } vec_t;

   vec_t tbl[21];

   pipe_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .MEM_TIMEOUT(WD_N)) dut (
      .clk(clk), .rst(rst),
      .id_pause_i(id_pause_i), .br_taken_i(br_taken_i),
      .mdu_start_i(mdu_start_i), .mdu_div_i(mdu_div_i),
      .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
      .stall_o(stall_o), .flush_o(flush_o),
      .mdu_busy_o(mdu_busy_o), .mdu_done_o(mdu_done_o),
      .mem_timeout_o(mem_timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, p, b, s, d, q, a,
                               input logic [4:0] st, fl,
                               input logic dn, bz, t);
      vec_t v;
      v.rst = r; v.pause = p; v.br = b; v.start = s; v.div = d; v.req = q; v.ack = a;
      v.stall = st; v.flush = fl; v.done = dn; v.busy = bz; v.to = t;
      return v;
   endfunction

   // Drive one cycle's inputs just after a falling edge, check mid low phase,
   // then move to the next falling edge (one rising edge in between).
   task automatic apply(input vec_t v, input string tag, input int idx);
      rst = v.rst; id_pause_i = v.pause; br_taken_i = v.br;
      mdu_start_i = v.start; mdu_div_i = v.div; mem_req_i = v.req; mem_ack_i = v.ack;
      #2;
      n_vec++;
      if (stall_o !== v.stall) begin
         n_err++; $display("FAIL %s[%0d] stall_o got %b exp %b", tag, idx, stall_o, v.stall);
      end
      if (flush_o !== v.flush) begin
         n_err++; $display("FAIL %s[%0d] flush_o got %b exp %b", tag, idx, flush_o, v.flush);
      end
      if (mdu_done_o !== v.done) begin
         n_err++; $display("FAIL %s[%0d] mdu_done_o got %b exp %b", tag, idx, mdu_done_o, v.done);
      end
      if (mdu_busy_o !== v.busy) begin
         n_err++; $display("FAIL %s[%0d] mdu_busy_o got %b exp %b", tag, idx, mdu_busy_o, v.busy);
      end
      if (mem_timeout_o !== v.to) begin
         n_err++; $display("FAIL %s[%0d] mem_timeout_o got %b exp %b", tag, idx, mem_timeout_o, v.to);
      end
      @(negedge clk);
   endtask

   initial begin
      //            rst p b s d q a  stall     flush    dn bz to
      tbl[0]  = mk(1, 0,0,1,0,1,0, 5'b00000, 5'b00000, 0, 0, 0); // forced zero in reset
      tbl[1]  = mk(0, 0,0,0,0,0,0, 5'b00000, 5'b00000, 0, 0, 0);
      tbl[2]  = mk(0, 0,0,1,0,0,0, 5'b00111, 5'b01000, 0, 0, 0); // mul cycle 0
      tbl[3]  = mk(0, 0,0,0,0,0,0, 5'b00111, 5'b01000, 0, 1, 0); // cnt 3
      tbl[4]  = mk(0, 0,0,0,0,0,0, 5'b00111, 5'b01000, 0, 1, 0); // cnt 2
      tbl[5]  = mk(0, 0,0,0,0,0,0, 5'b00111, 5'b01000, 0, 1, 0); // cnt 1
      tbl[6]  = mk(0, 0,0,0,0,0,0, 5'b00000, 5'b00000, 1, 1, 0); // cnt 0 -> done
      tbl[7]  = mk(0, 0,0,0,0,0,0, 5'b00000, 5'b00000, 0, 0, 0);
      tbl[8]  = mk(0, 1,1,0,0,0,0, 5'b00011, 5'b00100, 0, 0, 0); // load-use masks branch
      tbl[9]  = mk(0, 0,1,0,0,0,0, 5'b00000, BRF,      0, 0, 0); // branch alone
      tbl[10] = mk(0, 1,0,0,0,0,0, 5'b00011, 5'b00100, 0, 0, 0);
      tbl[11] = mk(0, 1,1,0,0,1,0, 5'b01111, 5'b10000, 0, 0, 0); // memwait wins
      tbl[12] = mk(0, 0,0,0,0,1,1, 5'b00000, 5'b00000, 0, 0, 0); // req+ack: no wait
      tbl[13] = mk(0, 0,0,1,0,1,0, 5'b01111, 5'b10000, 0, 0, 0); // start not sampled
      tbl[14] = mk(0, 0,0,1,0,0,0, 5'b00111, 5'b01000, 0, 0, 0); // start sampled now
      tbl[15] = mk(0, 0,0,1,1,0,0, 5'b00111, 5'b01000, 0, 1, 0); // start in BUSY ignored
      tbl[16] = mk(0, 0,1,0,0,0,0, 5'b00111, 5'b01000, 0, 1, 0); // branch held
      tbl[17] = mk(0, 0,0,0,0,0,0, 5'b00111, 5'b01000, 0, 1, 0); // cnt 1
      tbl[18] = mk(0, 0,0,0,0,1,0, 5'b01111, 5'b10000, 0, 1, 0); // cnt 0, wait
      tbl[19] = mk(0, 0,0,0,0,0,0, 5'b00000, 5'b00000, 1, 1, 0); // release
      tbl[20] = mk(0, 0,0,0,0,0,0, 5'b00000, 5'b00000, 0, 0, 0);

      rst = 1'b1; id_pause_i = 0; br_taken_i = 0; mdu_start_i = 0; mdu_div_i = 0;
      mem_req_i = 0; mem_ack_i = 0;
      @(negedge clk);
      @(negedge clk);

      for (int i = 0; i < 21; i++) apply(tbl[i], "tbl", i);

      // Watchdog: 6 wait cycles, flag after the 4th wait edge, sticky after ack.
      for (int w = 0; w < 6; w++)
         apply(mk(0, 0,0,0,0,1,0, 5'b01111, 5'b10000, 0, 0, (w >= int'(WD_N))), "wdog", w);
      apply(mk(0, 0,0,0,0,1,1, 5'b00000, 5'b00000, 0, 0, 1), "wdog", 6);
      apply(mk(0, 0,0,0,0,0,0, 5'b00000, 5'b00000, 0, 0, 1), "wdog", 7);
      apply(mk(1, 0,0,0,0,1,0, 5'b00000, 5'b00000, 0, 0, 1), "wdog", 8);
      apply(mk(0, 0,0,0,0,0,0, 5'b00000, 5'b00000, 0, 0, 0), "wdog", 9);

      // Divide with memwait in cycles 30..35; count runs through, done in 36.
      for (int k = 0; k <= 36; k++) begin
         logic       mw;
         logic [4:0] es, ef;
         mw = (k >= 30 && k <= 35);
         if (mw) begin
            es = 5'b01111; ef = 5'b10000;
         end else if (k <= 31) begin
            es = 5'b00111; ef = 5'b01000;
         end else begin
            es = 5'b00000; ef = 5'b00000;
         end
         apply(mk(0, 0,0,(k == 0),(k == 0),mw,0, es, ef, (k == 36), (k >= 1),
                  (k >= 30 + int'(WD_N))), "div", k);
      end
      apply(mk(0, 0,0,0,0,0,0, 5'b00000, 5'b00000, 0, 0, 1), "div", 37);

      // Reset mid-divide at cnt=10 (cycle 22), then a fresh multiply.
      for (int k = 0; k < 22; k++)
         apply(mk(0, 0,0,(k == 0),1,0,0, 5'b00111, 5'b01000, 0, (k >= 1), 1), "rdiv", k);
      apply(mk(1, 0,0,0,0,0,0, 5'b00000, 5'b00000, 0, 1, 1), "rdiv", 22);
      apply(mk(0, 0,0,0,0,0,0, 5'b00000, 5'b00000, 0, 0, 0), "rdiv", 23);
      for (int k = 0; k <= int'(MUL_N); k++) begin
         logic [4:0] es, ef;
         es = (k < int'(MUL_N)) ? 5'b00111 : 5'b00000;
         ef = (k < int'(MUL_N)) ? 5'b01000 : 5'b00000;
         apply(mk(0, 0,0,(k == 0),0,0,0, es, ef, (k == int'(MUL_N)), (k >= 1), 0), "rmul", k);
      end
      apply(mk(0, 0,0,0,0,0,0, 5'b00000, 5'b00000, 0, 0, 0), "rmul", 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
